// File: rtl/score_keeper_pkg.sv
// Shared constants and the hit-multiplier helper for the score keeper.
package score_keeper_pkg;

   localparam int ARROW_W     = 4;
   localparam int STATE_W     = 2;
   localparam int VAL_W       = 14;
   localparam int MAX_VAL     = 9999;
   localparam int BASE_POINTS = 10;
   localparam int PENALTY     = 5;
   localparam int COMBO_STEP  = 10;
   localparam int MAX_MULT    = 4;
   localparam int COMBO_SHOW  = 2;
   localparam logic [STATE_W-1:0] ST_RUN = 2'b01;

   // Points for a correct hit, from the combo value before it increments.
   function automatic logic [VAL_W-1:0] hitPoints(input logic [VAL_W-1:0] comboNow);
      logic [VAL_W-1:0] step;
      logic [VAL_W-1:0] mult;
      step = VAL_W'(comboNow / COMBO_STEP);
      mult = (step >= VAL_W'(MAX_MULT - 1)) ? VAL_W'(MAX_MULT) : step + 1'b1;
      return VAL_W'(BASE_POINTS * mult);
   endfunction

endpackage

// File: rtl/score_keeper_sat_add_sub.sv
// 14-bit add/subtract clamped to [0, MAX_VAL]; one extra bit catches overflow and borrow.
module sat_add_sub
   import score_keeper_pkg::*;
(
   input  logic [VAL_W-1:0] a,
   input  logic [VAL_W-1:0] b,
   input  logic             sub,
   output logic [VAL_W-1:0] y
);

   logic [VAL_W:0] sum;
   logic [VAL_W:0] diff;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      if (sub)
         y = diff[VAL_W] ? '0 : diff[VAL_W-1:0];
      else
         y = (sum > (VAL_W+1)'(MAX_VAL)) ? VAL_W'(MAX_VAL) : sum[VAL_W-1:0];
   end

endmodule

// File: rtl/score_keeper.sv
// Turns per-beat hit judgements into score, combo and best combo for the display stage.
module score_keeper
   import score_keeper_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [STATE_W-1:0] state,
   input  logic               new_game,
   input  logic               metronome,
   input  logic [ARROW_W-1:0] target_arrow,
   input  logic               correct_hit,
   input  logic               incorrect_hit,
   output logic [VAL_W-1:0]   score,
   output logic [VAL_W-1:0]   combo,
   output logic [VAL_W-1:0]   best_combo,
   output logic               combo_en,
   output logic               miss_pulse
);

   logic metroQ, correctQ, incorrectQ, arrowQ;
   logic judged, windowOpen;
   logic run, beatEdge, correctEdge, incorrectEdge, hitEvt;
   logic [VAL_W-1:0] scoreOperand, scoreSum, comboInc;
   logic [VAL_W-1:0] scoreNext, comboNext;
   logic judgedNext, missNext, openNext;

   assign run           = (state == ST_RUN);
   assign beatEdge      = metronome & ~metroQ;
   assign correctEdge   = correct_hit & ~correctQ;
   assign incorrectEdge = incorrect_hit & ~incorrectQ;
   assign hitEvt        = run & (correctEdge | incorrectEdge) & ~judged;
   assign scoreOperand  = incorrectEdge ? VAL_W'(PENALTY) : hitPoints(combo);

   sat_add_sub scoreUnit (
      .a   (score),
      .b   (scoreOperand),
      .sub (incorrectEdge),
      .y   (scoreSum)
   );

   sat_add_sub comboUnit (
      .a   (combo),
      .b   (VAL_W'(1)),
      .sub (1'b0),
      .y   (comboInc)
   );

   // A hit landing on the closing beat edge belongs to the closing window, so it suppresses the miss.
   always_comb begin
      scoreNext  = score;
      comboNext  = combo;
      judgedNext = judged;
      missNext   = 1'b0;
      openNext   = windowOpen;
      if (run) begin
         if (hitEvt) begin
            scoreNext = scoreSum;
            comboNext = incorrectEdge ? '0 : comboInc;
         end else if (beatEdge && arrowQ && !judged && windowOpen) begin
            comboNext = '0;
            missNext  = 1'b1;
         end
         if (beatEdge) begin
            judgedNext = 1'b0;
            openNext   = 1'b1;
         end else if (hitEvt) begin
            judgedNext = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         metroQ     <= 1'b0;
         correctQ   <= 1'b0;
         incorrectQ <= 1'b0;
         arrowQ     <= 1'b0;
         judged     <= 1'b0;
         windowOpen <= 1'b0;
         score      <= '0;
         combo      <= '0;
         best_combo <= '0;
         combo_en   <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         // Edge history tracks inputs even while paused so resuming never fakes an event.
         metroQ     <= metronome;
         correctQ   <= correct_hit;
         incorrectQ <= incorrect_hit;
         arrowQ     <= |target_arrow;
         combo_en   <= (combo >= VAL_W'(COMBO_SHOW));
         if (new_game) begin
            score      <= '0;
            combo      <= '0;
            judged     <= 1'b0;
            miss_pulse <= 1'b0;
         end else begin
            score      <= scoreNext;
            combo      <= comboNext;
            judged     <= judgedNext;
            windowOpen <= openNext;
            miss_pulse <= missNext;
            if (comboNext > best_combo)
               best_combo <= comboNext;
         end
      end
   end

endmodule

// File: tb/tb_score_keeper.sv
// Directed checks of scoring, combo, miss detection, pause, reset and saturation.
module tb_score_keeper;

   logic        clk;
   logic        reset;
   logic [1:0]  state;
   logic        new_game;
   logic        metronome;
   logic [3:0]  target_arrow;
   logic        correct_hit;
   logic        incorrect_hit;
   logic [13:0] score;
   logic [13:0] combo;
   logic [13:0] best_combo;
   logic        combo_en;
   logic        miss_pulse;

   int nChecks = 0;
   int nFails  = 0;

   score_keeper dut (
      .clk           (clk),
      .reset         (reset),
      .state         (state),
      .new_game      (new_game),
      .metronome     (metronome),
      .target_arrow  (target_arrow),
      .correct_hit   (correct_hit),
      .incorrect_hit (incorrect_hit),
      .score         (score),
      .combo         (combo),
      .best_combo    (best_combo),
      .combo_en      (combo_en),
      .miss_pulse    (miss_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic openBeat();
      metronome = 1'b1;
      tick();
      metronome = 1'b0;
      tick();
   endtask

   task automatic hit(input logic c, input logic i);
      correct_hit   = c;
      incorrect_hit = i;
      tick();
      correct_hit   = 1'b0;
      incorrect_hit = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; state = 2'b00; new_game = 1'b0; metronome = 1'b0;
      target_arrow = '0; correct_hit = 1'b0; incorrect_hit = 1'b0;
      tick(); tick();
      checkVal("rst_score", score, 0);
      checkVal("rst_combo", combo, 0);
      checkVal("rst_best", best_combo, 0);
      checkVal("rst_en", combo_en, 0);
      checkVal("rst_miss", miss_pulse, 0);
      reset = 1'b0; state = 2'b01;
      tick();

      // 12 correct beats: 10 hits at x1, 2 hits at x2
      openBeat(); hit(1, 0);
      openBeat();
      correct_hit = 1'b1; tick();
      checkVal("combo2", combo, 2);
      checkVal("en_lag", combo_en, 0);
      correct_hit = 1'b0; tick();
      checkVal("en_rise", combo_en, 1);
      repeat (10) begin openBeat(); hit(1, 0); end
      checkVal("run_score", score, 140);
      checkVal("run_combo", combo, 12);
      checkVal("run_best", best_combo, 12);

      // incorrect hit
      openBeat(); hit(0, 1);
      checkVal("inc_score", score, 135);
      checkVal("inc_combo", combo, 0);
      checkVal("inc_best", best_combo, 12);
      checkVal("inc_en", combo_en, 0);

      // miss on a closing window with an arrow and no hit
      openBeat(); hit(1, 0);
      checkVal("pre_miss_combo", combo, 1);
      openBeat();
      target_arrow = 4'b0010; tick(); tick();
      metronome = 1'b1; tick();
      checkVal("miss_hi", miss_pulse, 1);
      checkVal("miss_combo", combo, 0);
      checkVal("miss_score", score, 145);
      metronome = 1'b0; target_arrow = '0; tick();
      checkVal("miss_lo", miss_pulse, 0);
      tick();
      metronome = 1'b1; tick();
      checkVal("nomiss_empty", miss_pulse, 0);
      metronome = 1'b0; tick();

      // hit coincident with closing edge
      target_arrow = 4'b0010; tick();
      metronome = 1'b1; correct_hit = 1'b1; tick();
      checkVal("coinc_miss", miss_pulse, 0);
      checkVal("coinc_combo", combo, 1);
      checkVal("coinc_score", score, 155);
      metronome = 1'b0; correct_hit = 1'b0; target_arrow = '0; tick();
      hit(1, 0);
      checkVal("newwin_score", score, 165);

      // double pulse in one window, then simultaneous hits
      openBeat(); hit(0, 1);
      checkVal("dbl_base", score, 160);
      openBeat(); hit(1, 0); hit(1, 0);
      checkVal("dbl_score", score, 170);
      checkVal("dbl_combo", combo, 1);
      openBeat(); hit(1, 1);
      checkVal("both_score", score, 165);
      checkVal("both_combo", combo, 0);

      // new_game and penalty floor
      new_game = 1'b1; tick(); new_game = 1'b0;
      checkVal("ng_score", score, 0);
      checkVal("ng_combo", combo, 0);
      checkVal("ng_best", best_combo, 12);
      openBeat(); hit(0, 1);
      checkVal("floor0", score, 0);
      openBeat(); hit(1, 0);
      openBeat(); hit(0, 1);
      checkVal("pen5", score, 5);
      openBeat(); hit(0, 1);
      checkVal("floor5", score, 0);

      // pause with correct_hit held across resume
      openBeat(); hit(1, 0);
      state = 2'b00; tick();
      metronome = 1'b1; correct_hit = 1'b1; tick();
      checkVal("pause_miss", miss_pulse, 0);
      metronome = 1'b0; target_arrow = 4'b0100; tick(); tick();
      state = 2'b01; tick(); tick();
      checkVal("resume_score", score, 10);
      checkVal("resume_combo", combo, 1);
      correct_hit = 1'b0; target_arrow = '0; tick();
      openBeat(); hit(1, 0);
      checkVal("after_resume", score, 20);

      // asynchronous reset mid-window
      target_arrow = 4'b0010; tick();
      #2 reset = 1'b1;
      #1;
      checkVal("ar_score", score, 0);
      checkVal("ar_combo", combo, 0);
      checkVal("ar_best", best_combo, 0);
      checkVal("ar_en", combo_en, 0);
      checkVal("ar_miss", miss_pulse, 0);
      #2 reset = 1'b0;
      tick(); tick();
      metronome = 1'b1; tick();
      checkVal("first_beat_nomiss", miss_pulse, 0);
      metronome = 1'b0; tick(); tick();
      metronome = 1'b1; tick();
      checkVal("second_beat_miss", miss_pulse, 1);
      metronome = 1'b0; target_arrow = '0; tick();

      // saturation: 600 after 30 hits, then 234 hits at +40
      repeat (264) begin openBeat(); hit(1, 0); end
      checkVal("pre_sat_score", score, 9960);
      checkVal("pre_sat_combo", combo, 264);
      openBeat(); hit(1, 0);
      checkVal("sat_score", score, 9999);
      checkVal("sat_combo", combo, 265);
      openBeat(); hit(1, 0);
      checkVal("sat_hold", score, 9999);
      checkVal("sat_best", best_combo, 266);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
